// File: rtl/alu_flag_register_if.sv
// Bus between the ALU result mux and the flag unit: the sampled op on one side,
// the registered flags, sticky flags and overflow count on the other.
interface alu_flag_register_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned OPW   = 4,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [OPW-1:0]   opcode;
  logic [W-1:0]     operand_a;
  logic [W-1:0]     operand_b;
  logic [W-1:0]     op_result;
  logic             add_cout;
  logic             sub_cout;
  logic             flag_clear;
  logic             out_valid;
  logic             negative;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic [3:0]       sticky_flags;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output in_valid, opcode, operand_a, operand_b, op_result,
           add_cout, sub_cout, flag_clear,
    input  out_valid, negative, zero, carry, overflow, sticky_flags, ovf_count
  );

  modport slave (
    input  in_valid, opcode, operand_a, operand_b, op_result,
           add_cout, sub_cout, flag_clear,
    output out_valid, negative, zero, carry, overflow, sticky_flags, ovf_count
  );
endinterface

// File: rtl/alu_flag_register.sv
// Registered N/Z/C/V flag unit with signed-overflow detection for ADD/SUB.
// Define ALU_FLAG_STICKY_EN to build the sticky flags and saturating overflow counter.
package alu_ops;
  localparam logic [3:0] ADD_OP  = 4'd0;
  localparam logic [3:0] SUB_OP  = 4'd1;
  localparam logic [3:0] AND_OP  = 4'd2;
  localparam logic [3:0] OR_OP   = 4'd3;
  localparam logic [3:0] XOR_OP  = 4'd4;
  localparam logic [3:0] PASS_OP = 4'd5;
endpackage

module alu_flag_register #(
  parameter int unsigned W     = 4,
  parameter int unsigned OPW   = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  alu_flag_register_if.slave bus
);
  import alu_ops::*;

  logic n_next, z_next, c_next, v_next;
  logic a_msb, b_msb, r_msb;
  logic valid_q, n_q, z_q, c_q, v_q;

  assign a_msb = bus.operand_a[W-1];
  assign b_msb = bus.operand_b[W-1];
  assign r_msb = bus.op_result[W-1];

  always_comb begin
    n_next = r_msb;
    z_next = (bus.op_result == '0);
    c_next = 1'b0;
    v_next = 1'b0;
    if (bus.opcode == OPW'(ADD_OP)) begin
      c_next = bus.add_cout;
      v_next = (a_msb == b_msb) && (r_msb != a_msb);
    end else if (bus.opcode == OPW'(SUB_OP)) begin
      c_next = bus.sub_cout;
      v_next = (a_msb != b_msb) && (r_msb != a_msb);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        n_q <= n_next;
        z_q <= z_next;
        c_q <= c_next;
        v_q <= v_next;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.negative  = n_q;
  assign bus.zero      = z_q;
  assign bus.carry     = c_q;
  assign bus.overflow  = v_q;

`ifdef ALU_FLAG_STICKY_EN
  logic [3:0]       sticky_q, sticky_base, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_base, cnt_d;

  // Clear zeroes the base first so a same-cycle valid op lands on a clean slate.
  always_comb begin
    sticky_base = bus.flag_clear ? '0 : sticky_q;
    cnt_base    = bus.flag_clear ? '0 : cnt_q;
    sticky_d    = sticky_base;
    cnt_d       = cnt_base;
    if (bus.in_valid) begin
      sticky_d = sticky_base | {n_next, z_next, c_next, v_next};
      if (v_next && (cnt_base != '1))
        cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.sticky_flags = sticky_q;
  assign bus.ovf_count    = cnt_q;
`else
  logic unused_flag_clear;
  assign unused_flag_clear = bus.flag_clear;
  assign bus.sticky_flags  = '0;
  assign bus.ovf_count     = '0;
`endif
endmodule
